mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

Multicycle control sequencer for the MIPS core. Steps every instruction through fetch, decode, execute, memory and write-back. Drives the PC, IR, register-file, ALU and memory-interface enables from the instruction parser's `opcode`/`funct` fields. Sits between the instruction parser and the shared datapath, and owns the only memory request port.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters (used only with `MIPS_MC_PERF_CNT_EN`).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: `instruction[31:26]` from the parser; valid while the IR is stable.
- `funct` in 6: `instruction[5:0]`.
- `zero` in 1: ALU zero flag; sampled in EXEC.
- `mem_ack` in 1: memory done; one-cycle pulse.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write qualifier for `mem_req`.
- `ir_we` out 1: IR load.
- `pc_we` out 1: PC load.
- `pc_src` out 2: PC source. 00 = PC+4, 01 = branch target, 10 = jump target.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `alu_src` out 1: 0 = rt, 1 = sign-extended immediate.
- `reg_we` out 1: register-file write enable.
- `reg_dst` out 2: 00 = rt, 01 = rd, 10 = r31.
- `mem_to_reg` out 1: write-back source. 0 = ALU, 1 = memory.
- `halted` out 1: sticky illegal-opcode flag.
- `state` out 3: current state, for debug.
- `cyc_cnt`, `ret_cnt` out `CNT_W`: only with `MIPS_MC_PERF_CNT_EN`.

## Operation
- States:
  - IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
  - Encodings are fixed.
- IDLE: always goes to FETCH on the next cycle. Entered only from reset.
- FETCH:
  - `mem_req`=1 and `mem_we`=0 are held until `mem_ack` is seen.
  - In the ack cycle: `ir_we`=1, `pc_we`=1, `pc_src`=00, then go to DECODE.
- DECODE: one cycle, no enables asserted. Next state:
  - opcode 0x00 or 0x3E (R-type), 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x05 BNE, 0x02 J, 0x03 JAL → EXEC.
  - Any other opcode → HALT.
- EXEC: one cycle.
  - R-type: `alu_op`=10, `alu_src`=0, then WB.
  - ADDI, LW, SW: `alu_op`=00, `alu_src`=1. ADDI then goes to WB; LW and SW go to MEM.
  - BEQ / BNE: `alu_op`=01, `alu_src`=0.
    - `pc_we` = `zero` for BEQ, `!zero` for BNE; `pc_src`=01.
    - Then FETCH.
  - J: `pc_we`=1, `pc_src`=10, then FETCH.
  - JAL: `pc_we`=1, `pc_src`=10, then WB.
- MEM:
  - `mem_req`=1, with `mem_we`=1 for SW and 0 for LW; held until `mem_ack`.
  - On ack: LW → WB, SW → FETCH.
- WB: `reg_we`=1 for one cycle, then FETCH. Write target:
  - R-type: `reg_dst`=01, `mem_to_reg`=0.
  - ADDI: `reg_dst`=00, `mem_to_reg`=0.
  - LW: `reg_dst`=00, `mem_to_reg`=1.
  - JAL: `reg_dst`=10, `mem_to_reg`=0.
- HALT: absorbing; `halted`=1. Only `rst_n` leaves it.
- The opcode class is latched into a 3-bit register in DECODE. EXEC, MEM and WB use the latched class, not the live `opcode`.
- Enables (`ir_we`, `pc_we`, `reg_we`, `mem_req`) are asserted only in the states listed above; every other output is 0 outside them.

## Timing
- While `rst_n`=0 and in IDLE:
  - `state`=IDLE and all outputs are 0, including `halted`.
  - Counters read 0.
- Latency with zero-wait memory (`mem_ack` high in the first FETCH/MEM cycle):
  - J, BEQ, BNE: 3 cycles.
  - R-type, ADDI, SW, JAL: 4 cycles.
  - LW: 5 cycles.
  - Each extra wait cycle adds 1.
- `mem_req`, `mem_we` and the ALU controls are Moore outputs decoded from `state`.
- `ir_we` and the FETCH `pc_we` are Mealy outputs: `state`==FETCH && `mem_ack`.
- `mem_ack` outside FETCH/MEM is ignored.
- Reset asserted mid-instruction returns to IDLE immediately. Outputs are cleared asynchronously, and no partial write completes after reset.

## Configuration
- `MIPS_MC_PERF_CNT_EN` defined:
  - `cyc_cnt` increments every cycle outside IDLE/HALT.
  - `ret_cnt` increments on every transition into FETCH from EXEC, MEM or WB.
  - Both wrap modulo 2^`CNT_W` and are cleared by reset.
- `MIPS_MC_PERF_CNT_EN` undefined: the ports and counter logic are absent.

## Structure
- Package `mips_ctrl_pkg` holds:
  - The state enum.
  - The opcode constants (0x00, 0x3E, 0x02, 0x03, 0x04, 0x05, 0x08, 0x23, 0x2B).
  - The opcode-class enum.
  - The `alu_op`, `pc_src` and `reg_dst` encodings.
- Sub-module `mips_op_class`: combinational map from opcode to class plus an illegal flag. Instantiated once, feeding the DECODE latch.

## Test plan
- Reset release, `mem_ack` tied 1:
  - IDLE for 1 cycle, then FETCH with `mem_req`=1.
  - `ir_we` and `pc_we` pulse in the same cycle.
- R-type (opcode 0x00), zero wait: states 1→2→3→5→1 over 4 cycles; `reg_we`=1 with `reg_dst`=01 in cycle 4.
- LW (0x23), `mem_ack` delayed 3 cycles in MEM:
  - MEM lasts 3 cycles with `mem_req`=1 and `mem_we`=0.
  - WB follows with `mem_to_reg`=1.
  - Total 7 cycles.
- Branches:
  - BEQ with `zero`=1: `pc_we`=1, `pc_src`=01 in EXEC.
  - BNE with `zero`=1: `pc_we`=0 in EXEC.
  - Both return to FETCH.
- Opcode 0x3F: after DECODE, `state`=6 and `halted`=1 persist for 20 cycles regardless of `mem_ack`; `rst_n` pulse returns to IDLE.
- Asynchronous reset:
  - Assert `rst_n`=0 mid-MEM of an SW: `mem_req` and `mem_we` drop without waiting for a clock edge.
  - With `MIPS_MC_PERF_CNT_EN`: `ret_cnt` reads 0 after reset and 3 after three J instructions.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
// State, opcode-class and datapath select encodings are fixed here for all users.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_RTYPE2 = 6'h3E;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_BNE  = 3'd5,
    CLS_J    = 3'd6,
    CLS_JAL  = 3'd7
  } op_class_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

endpackage

// File: rtl/mips_op_class.sv
// Combinational opcode-to-class map; anything not recognised is flagged illegal.
module mips_op_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);

  always_comb begin
    op_class = CLS_R;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE, OP_RTYPE2: op_class = CLS_R;
      OP_ADDI:             op_class = CLS_ADDI;
      OP_LW:               op_class = CLS_LW;
      OP_SW:               op_class = CLS_SW;
      OP_BEQ:              op_class = CLS_BEQ;
      OP_BNE:              op_class = CLS_BNE;
      OP_J:                op_class = CLS_J;
      OP_JAL:              op_class = CLS_JAL;
      default:             illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky HALT on illegal opcodes.
// Optional performance counters are built when MIPS_MC_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | post-reset, one cycle
// FETCH  | instruction read, waits for mem_ack
// DECODE | classify opcode, latch class
// EXEC   | ALU op / branch / jump
// MEM    | data read or write, waits for mem_ack
// WB     | register-file write
// HALT   | illegal opcode seen, absorbing
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic [2:0]       state
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  state_t    st_q, st_nxt;
  op_class_t cls_q;
  op_class_t dec_cls;
  logic      dec_illegal;

  // funct is consumed by the ALU decoder downstream, not by the sequencer
  logic unused_funct;
  assign unused_funct = ^funct;

  mips_op_class u_op_class (
    .opcode   (opcode),
    .op_class (dec_cls),
    .illegal  (dec_illegal)
  );

  always_comb begin
    st_nxt = st_q;
    case (st_q)
      ST_IDLE:   st_nxt = ST_FETCH;
      ST_FETCH:  if (mem_ack) st_nxt = ST_DECODE;
      ST_DECODE: st_nxt = dec_illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (cls_q)
          CLS_R, CLS_ADDI, CLS_JAL: st_nxt = ST_WB;
          CLS_LW, CLS_SW:           st_nxt = ST_MEM;
          default:                  st_nxt = ST_FETCH;
        endcase
      end
      ST_MEM:    if (mem_ack) st_nxt = (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
      ST_WB:     st_nxt = ST_FETCH;
      ST_HALT:   st_nxt = ST_HALT;
      default:   st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      cls_q <= CLS_R;
    end else begin
      st_q <= st_nxt;
      if (st_q == ST_DECODE && !dec_illegal)
        cls_q <= dec_cls;
    end
  end

  // Outputs decode from the registered state so an async reset clears them at once
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (st_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
        pc_we   = mem_ack;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R: alu_op = ALU_FUNCT;
          CLS_ADDI, CLS_LW, CLS_SW: begin
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
          end
          CLS_BEQ, CLS_BNE: begin
            alu_op = ALU_SUB;
            pc_src = PC_BRANCH;
            pc_we  = (cls_q == CLS_BEQ) ? zero : !zero;
          end
          default: begin
            pc_we  = 1'b1;
            pc_src = PC_JUMP;
          end
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_SW);
      end
      ST_WB: begin
        reg_we = 1'b1;
        case (cls_q)
          CLS_R:   reg_dst = RD_RD;
          CLS_LW:  mem_to_reg = 1'b1;
          CLS_JAL: reg_dst = RD_R31;
          default: reg_dst = RD_RT;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = st_q;

`ifdef MIPS_MC_PERF_CNT_EN
  logic retire;
  assign retire = (st_nxt == ST_FETCH) &&
                  (st_q == ST_EXEC || st_q == ST_MEM || st_q == ST_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (st_q != ST_IDLE && st_q != ST_HALT)
        cyc_cnt <= cyc_cnt + 1'b1;
      if (retire)
        ret_cnt <= ret_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: stimulus queues per-cycle expectations, monitor checks at negedge.
module tb_mips_mc_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic             mem_ack = 1'b0;
  logic             mem_req, mem_we, ir_we, pc_we, alu_src, reg_we, mem_to_reg, halted;
  logic [1:0]       pc_src, alu_op, reg_dst;
  logic [2:0]       state;
`ifdef MIPS_MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt, ret_cnt;
`endif

  int checks = 0;
  int errs   = 0;

  typedef struct {
    string      nm;
    logic [16:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mips_mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .halted(halted), .state(state)
`ifdef MIPS_MC_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // {state, mem_req, mem_we, ir_we, pc_we, pc_src, alu_op, alu_src, reg_we, reg_dst, mem_to_reg, halted}
  function automatic logic [16:0] ex(input logic [2:0] s, input logic req, we, ir, pc,
                                     input logic [1:0] psrc, aop, input logic asrc, rwe,
                                     input logic [1:0] rdst, input logic m2r, hlt);
    return {s, req, we, ir, pc, psrc, aop, asrc, rwe, rdst, m2r, hlt};
  endfunction

  function automatic logic [16:0] e_idle();
    return ex(3'd0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
  endfunction
  function automatic logic [16:0] e_fetch(input logic ack);
    return ex(3'd1, 1, 0, ack, ack, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
  endfunction
  function automatic logic [16:0] e_dec();
    return ex(3'd2, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
  endfunction
  function automatic logic [16:0] e_halt();
    return ex(3'd6, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 1);
  endfunction

  task automatic cyc(input string nm, input logic r, input logic [5:0] op,
                     input logic z, input logic ack, input logic [16:0] e);
    exp_t it;
    @(posedge clk);
    #1;
    rst_n = r; opcode = op; zero = z; mem_ack = ack;
    it.nm = nm; it.v = e;
    sb.push_back(it);
  endtask

  task automatic fd(input string nm, input logic [5:0] op);
    cyc({nm, "_fetch"}, 1, op, 0, 1, e_fetch(1));
    cyc({nm, "_decode"}, 1, op, 0, 0, e_dec());
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares it with the DUT outputs
  initial begin
    exp_t it;
    logic [16:0] obs;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        it  = sb.pop_front();
        obs = {state, mem_req, mem_we, ir_we, pc_we, pc_src, alu_op, alu_src,
               reg_we, reg_dst, mem_to_reg, halted};
        checks++;
        if (obs !== it.v) begin
          errs++;
          $display("FAIL %s: got %05h expected %05h", it.nm, obs, it.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with mem_ack high: nothing moves, everything 0
    cyc("rst0", 0, 6'h00, 0, 1, e_idle());
    cyc("rst1", 0, 6'h00, 0, 1, e_idle());
`ifdef MIPS_MC_PERF_CNT_EN
    chk("cnt_rst_ret", ret_cnt, 0);
    chk("cnt_rst_cyc", cyc_cnt, 0);
`endif
    cyc("idle", 1, 6'h00, 0, 1, e_idle());

    // R-type 0x00, zero wait
    fd("r", 6'h00);
    cyc("r_exec", 1, 6'h00, 0, 0, ex(3'd3, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0));
    cyc("r_wb", 1, 6'h00, 0, 0, ex(3'd5, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b01, 0, 0));

    // LW with 3-cycle MEM; live opcode scrambled after DECODE
    fd("lw", 6'h23);
    cyc("lw_exec", 1, 6'h3F, 0, 0, ex(3'd3, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 0));
    cyc("lw_mem0", 1, 6'h2B, 0, 0, ex(3'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("lw_mem1", 1, 6'h2B, 0, 0, ex(3'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("lw_mem2", 1, 6'h2B, 0, 1, ex(3'd4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("lw_wb", 1, 6'h3F, 0, 1, ex(3'd5, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 1, 0));

    // ADDI
    fd("addi", 6'h08);
    cyc("addi_exec", 1, 6'h08, 0, 0, ex(3'd3, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 0));
    cyc("addi_wb", 1, 6'h08, 0, 1, ex(3'd5, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 0));

    // SW zero wait
    fd("sw", 6'h2B);
    cyc("sw_exec", 1, 6'h2B, 0, 0, ex(3'd3, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 0));
    cyc("sw_mem", 1, 6'h2B, 0, 1, ex(3'd4, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0));

    // BEQ taken / BNE not taken, both with zero=1
    fd("beq", 6'h04);
    cyc("beq_exec", 1, 6'h04, 1, 1, ex(3'd3, 0, 0, 0, 1, 2'b01, 2'b01, 0, 0, 2'b00, 0, 0));
    fd("bne", 6'h05);
    cyc("bne_exec", 1, 6'h05, 1, 1, ex(3'd3, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, 0, 0));

    // BNE with zero=0 is taken
    fd("bne_t", 6'h05);
    cyc("bne_t_exec", 1, 6'h05, 0, 0, ex(3'd3, 0, 0, 0, 1, 2'b01, 2'b01, 0, 0, 2'b00, 0, 0));

    // JAL
    fd("jal", 6'h03);
    cyc("jal_exec", 1, 6'h03, 0, 0, ex(3'd3, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("jal_wb", 1, 6'h03, 0, 0, ex(3'd5, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 0));

    // J with one FETCH wait cycle
    cyc("j_fetchw", 1, 6'h02, 0, 0, e_fetch(0));
    fd("j", 6'h02);
    cyc("j_exec", 1, 6'h02, 0, 1, ex(3'd3, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0));

    // R-type alias 0x3E
    fd("r3e", 6'h3E);
    cyc("r3e_exec", 1, 6'h3E, 0, 0, ex(3'd3, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0));
    cyc("r3e_wb", 1, 6'h3E, 0, 0, ex(3'd5, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b01, 0, 0));

    // SW interrupted by async reset in MEM
    fd("swr", 6'h2B);
    cyc("swr_exec", 1, 6'h2B, 0, 0, ex(3'd3, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 0));
    @(posedge clk);
    #1;
    mem_ack = 0;
    #1;
    chk("swr_mem_req_pre", {mem_req, mem_we}, 2'b11);
    rst_n = 0;
    #1;
    chk("swr_mem_req_async", {mem_req, mem_we}, 2'b00);
    chk("swr_state_async", state, 0);
    cyc("swr_rst", 0, 6'h2B, 0, 1, e_idle());
    cyc("swr_idle", 1, 6'h2B, 0, 1, e_idle());

    // illegal opcode 0x3F: HALT absorbs for 20 cycles whatever mem_ack does
    fd("ill", 6'h3F);
    for (int i = 0; i < 20; i++)
      cyc("halt", 1, 6'h02, 0, i[0], e_halt());
    cyc("halt_rst", 0, 6'h02, 0, 1, e_idle());
`ifdef MIPS_MC_PERF_CNT_EN
    chk("cnt_ret_zero", ret_cnt, 0);
`endif
    cyc("halt_idle", 1, 6'h02, 0, 1, e_idle());

    // three J instructions back to back
    for (int k = 0; k < 3; k++) begin
      fd("jp", 6'h02);
      cyc("jp_exec", 1, 6'h02, 0, 1, ex(3'd3, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0));
    end
    cyc("jp_fetch", 1, 6'h02, 0, 0, e_fetch(0));
`ifdef MIPS_MC_PERF_CNT_EN
    #2;
    chk("cnt_ret_three", ret_cnt, 3);
    chk("cnt_cyc_nine", cyc_cnt, 9);
`endif

    for (int w = 0; w < 10 && sb.size() != 0; w++)
      @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
